// File: rtl/config_pkg.sv
// Shared types and constants for the tile configuration loader.
package config_pkg;

    localparam int unsigned CFG_WORD_W    = 32;
    localparam int unsigned CFG_NUM_WORDS = 45;

    typedef enum logic [2:0] {
        IDLE,
        ACCEPT,
        SETUP,
        STROBE,
        HOLD,
        CHECK,
        DONE
    } state_t;

    // Width of a binary index over n items (at least one bit).
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/config_loader_if.sv
// Stream, latch-bank and status signals between the configuration controller and the loader.
interface config_loader_if #(
    parameter int unsigned WORD_W    = config_pkg::CFG_WORD_W,
    parameter int unsigned NUM_WORDS = config_pkg::CFG_NUM_WORDS
);

    logic                 io_start;
    logic                 io_abort;
    logic                 io_word_valid;
    logic [WORD_W-1:0]    io_word_data;
    logic                 io_word_ready;
    logic [WORD_W-1:0]    io_d_out;
    logic [NUM_WORDS-1:0] io_configs_en;
    logic                 io_busy;
    logic                 io_done;
    logic                 io_err;

    modport master (
        output io_start, io_abort, io_word_valid, io_word_data,
        input  io_word_ready, io_d_out, io_configs_en, io_busy, io_done, io_err
    );

    modport slave (
        input  io_start, io_abort, io_word_valid, io_word_data,
        output io_word_ready, io_d_out, io_configs_en, io_busy, io_done, io_err
    );

endinterface

// File: rtl/cfg_onehot_dec.sv
// Registered binary-to-one-hot decoder; enables come straight from flops so the
// latch bank never sees decode glitches.
module cfg_onehot_dec #(
    parameter int unsigned N     = 45,
    parameter int unsigned IDX_W = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             strobe,
    input  logic [IDX_W-1:0] idx,
    output logic [N-1:0]     en
);

    logic [N-1:0] en_next;

    always_comb begin
        en_next = '0;
        for (int unsigned i = 0; i < N; i++) begin
            en_next[i] = strobe && (idx == IDX_W'(i));
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            en <= '0;
        end else begin
            en <= en_next;
        end
    end

endmodule

// File: rtl/config_loader.sv
// Write-side sequencer for the tile configuration latch bank: one word, one
// enable pulse, ascending order, with an optional trailing XOR checksum.
module config_loader
    import config_pkg::*;
#(
    parameter int unsigned WORD_W    = CFG_WORD_W,
    parameter int unsigned NUM_WORDS = CFG_NUM_WORDS,
    parameter bit          CHECK_EN  = 1'b1
) (
    input logic            clk,
    input logic            reset,
    config_loader_if.slave bus
);

    localparam int unsigned      IDX_W    = idx_width(NUM_WORDS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_WORDS - 1);

    state_t              state;
    logic [IDX_W-1:0]    idx;
    logic [WORD_W-1:0]   acc;
    logic [WORD_W-1:0]   d_out;
    logic                done;
    logic                err;
    logic                handshake;
    logic                strobe;
    logic [NUM_WORDS-1:0] en;

    assign bus.io_word_ready = (state == ACCEPT) || (state == CHECK);
    assign bus.io_busy       = (state != IDLE);
    assign handshake         = bus.io_word_valid && bus.io_word_ready;
    // Arm the decoder one cycle early so its flop output is high exactly in STROBE.
    assign strobe            = (state == SETUP) && !bus.io_abort;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            idx   <= '0;
            acc   <= '0;
            d_out <= '0;
            done  <= 1'b0;
            err   <= 1'b0;
        end else if (state != IDLE && bus.io_abort) begin
            state <= IDLE;
            done  <= 1'b0;
            err   <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (bus.io_start) begin
                        state <= ACCEPT;
                        idx   <= '0;
                        acc   <= '0;
                        done  <= 1'b0;
                        err   <= 1'b0;
                    end
                end
                ACCEPT: begin
                    if (handshake) begin
                        d_out <= bus.io_word_data;
                        acc   <= acc ^ bus.io_word_data;
                        state <= SETUP;
                    end
                end
                SETUP:  state <= STROBE;
                STROBE: state <= HOLD;
                HOLD: begin
                    if (idx == LAST_IDX) begin
                        if (CHECK_EN) begin
                            state <= CHECK;
                        end else begin
                            state <= DONE;
                            done  <= 1'b1;
                        end
                    end else begin
                        idx   <= idx + IDX_W'(1);
                        state <= ACCEPT;
                    end
                end
                CHECK: begin
                    if (handshake) begin
                        err   <= (bus.io_word_data != acc);
                        done  <= 1'b1;
                        state <= DONE;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    cfg_onehot_dec #(
        .N     (NUM_WORDS),
        .IDX_W (IDX_W)
    ) u_dec (
        .clk    (clk),
        .reset  (reset),
        .strobe (strobe),
        .idx    (idx),
        .en     (en)
    );

    assign bus.io_d_out      = d_out;
    assign bus.io_configs_en = en;
    assign bus.io_done       = done;
    assign bus.io_err        = err;

endmodule

// File: tb/tb_config_loader.sv
// Directed scoreboard bench for config_loader: a 45-word checked instance and a
// 4-word unchecked instance.
module tb_config_loader;

    localparam int N0     = 45;
    localparam int N1     = 4;
    localparam int BUDGET = 60;

    typedef struct {
        int          idx;
        logic [31:0] data;
    } sb_t;

    logic clk = 1'b0;
    logic reset;
    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail  = 0;

    sb_t  sb0[$];
    sb_t  sb1[$];
    int   strobe_cyc0[$];
    int   strobe_cyc1[$];
    int   done_cyc0 = 0;
    int   done_cyc1 = 0;
    logic done0_q = 1'b0;
    logic done1_q = 1'b0;

    config_loader_if #(.WORD_W(32), .NUM_WORDS(N0)) if0 ();
    config_loader_if #(.WORD_W(32), .NUM_WORDS(N1)) if1 ();

    config_loader #(.WORD_W(32), .NUM_WORDS(N0), .CHECK_EN(1'b1)) u_dut0 (
        .clk   (clk),
        .reset (reset),
        .bus   (if0)
    );

    config_loader #(.WORD_W(32), .NUM_WORDS(N1), .CHECK_EN(1'b0)) u_dut1 (
        .clk   (clk),
        .reset (reset),
        .bus   (if1)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
        end
    endtask

    // Every enable pulse must match the oldest word still owed a strobe.
    always @(negedge clk) begin
        sb_t e;
        if (if0.io_configs_en !== '0) begin
            chk("sb0_pending", 64'(sb0.size() > 0), 64'd1);
            if (sb0.size() > 0) begin
                e = sb0.pop_front();
                chk("sb0_en", 64'(if0.io_configs_en), 64'd1 << e.idx);
                chk("sb0_data", 64'(if0.io_d_out), 64'(e.data));
            end
            strobe_cyc0.push_back(cyc);
        end
        if (if0.io_done && !done0_q) done_cyc0 = cyc;
        done0_q = if0.io_done;
    end

    always @(negedge clk) begin
        sb_t e;
        if (if1.io_configs_en !== '0) begin
            chk("sb1_pending", 64'(sb1.size() > 0), 64'd1);
            if (sb1.size() > 0) begin
                e = sb1.pop_front();
                chk("sb1_en", 64'(if1.io_configs_en), 64'd1 << e.idx);
                chk("sb1_data", 64'(if1.io_d_out), 64'(e.data));
            end
            strobe_cyc1.push_back(cyc);
        end
        if (if1.io_done && !done1_q) done_cyc1 = cyc;
        done1_q = if1.io_done;
    end

    task automatic start_load(input int sel, output int sc);
        if (sel == 0) if0.io_start = 1'b1; else if1.io_start = 1'b1;
        @(negedge clk);
        if0.io_start = 1'b0;
        if1.io_start = 1'b0;
        sc = cyc;
    endtask

    // Present a word and return at the falling edge after its handshake.
    task automatic send(input int sel, input logic [31:0] w, input bit push, input int idx);
        int   c;
        logic rdy;
        if (push) begin
            if (sel == 0) sb0.push_back('{idx, w}); else sb1.push_back('{idx, w});
        end
        if (sel == 0) begin if0.io_word_valid = 1'b1; if0.io_word_data = w; end
        else          begin if1.io_word_valid = 1'b1; if1.io_word_data = w; end
        c   = 0;
        rdy = (sel == 0) ? if0.io_word_ready : if1.io_word_ready;
        while (!rdy && c < BUDGET) begin
            @(negedge clk);
            c++;
            rdy = (sel == 0) ? if0.io_word_ready : if1.io_word_ready;
        end
        chk("handshake_timeout", 64'(c >= BUDGET), 64'd0);
        @(negedge clk);
    endtask

    task automatic wait_done(input int sel);
        int   c;
        logic d;
        c = 0;
        d = (sel == 0) ? if0.io_done : if1.io_done;
        while (!d && c < BUDGET) begin
            @(negedge clk);
            c++;
            d = (sel == 0) ? if0.io_done : if1.io_done;
        end
        chk("done_timeout", 64'(c >= BUDGET), 64'd0);
        @(negedge clk);
    endtask

    initial begin
        int          sc;
        int          bad;
        logic [31:0] w;
        logic [31:0] csum;
        logic [31:0] w2;
        logic [31:0] w10;

        reset = 1'b1;
        if0.io_start = 1'b0; if0.io_abort = 1'b0; if0.io_word_valid = 1'b0; if0.io_word_data = '0;
        if1.io_start = 1'b0; if1.io_abort = 1'b0; if1.io_word_valid = 1'b0; if1.io_word_data = '0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_d_out", 64'(if0.io_d_out), 64'd0);
        chk("rst_en", 64'(if0.io_configs_en), 64'd0);
        chk("rst_busy", 64'(if0.io_busy), 64'd0);
        chk("rst_ready", 64'(if0.io_word_ready), 64'd0);
        chk("rst_done", 64'(if0.io_done), 64'd0);
        chk("rst_err", 64'(if0.io_err), 64'd0);
        chk("rst_en1", 64'(if1.io_configs_en), 64'd0);
        reset = 1'b0;
        @(negedge clk);
        chk("idle_busy", 64'(if0.io_busy), 64'd0);

        // Unchecked 4-word instance: done after 4*4+1 cycles, no checksum handshake.
        start_load(1, sc);
        for (int i = 0; i < N1; i++) send(1, 32'hC0DE_0000 + 32'(i), 1'b1, i);
        wait_done(1);
        chk("nock_done_cycle", 64'(done_cyc1 - sc + 1), 64'd17);
        chk("nock_err", 64'(if1.io_err), 64'd0);
        chk("nock_done_sticky", 64'(if1.io_done), 64'd1);
        chk("nock_ready", 64'(if1.io_word_ready), 64'd0);
        chk("nock_strobes", 64'(strobe_cyc1.size()), 64'd4);
        chk("nock_sb_drained", 64'(sb1.size()), 64'd0);

        // Full load with the correct checksum and valid held high.
        strobe_cyc0.delete();
        start_load(0, sc);
        csum = '0;
        for (int i = 0; i < N0; i++) begin
            w = 32'h1000_0000 + 32'(i);
            csum ^= w;
            send(0, w, 1'b1, i);
        end
        send(0, csum, 1'b0, 0);
        wait_done(0);
        chk("full_done_cycle", 64'(done_cyc0 - sc + 1), 64'd182);
        chk("full_done", 64'(if0.io_done), 64'd1);
        chk("full_err", 64'(if0.io_err), 64'd0);
        chk("full_busy_after", 64'(if0.io_busy), 64'd0);
        chk("full_strobes", 64'(strobe_cyc0.size()), 64'd45);
        chk("full_first_strobe", 64'(strobe_cyc0[0] - sc + 1), 64'd3);
        bad = 0;
        for (int i = 1; i < strobe_cyc0.size(); i++)
            if (strobe_cyc0[i] - strobe_cyc0[i-1] != 4) bad++;
        chk("full_strobe_gap", 64'(bad), 64'd0);
        chk("full_sb_drained", 64'(sb0.size()), 64'd0);

        // Corrupted checksum: err rises and is held until the next start.
        start_load(0, sc);
        for (int i = 0; i < N0; i++) send(0, 32'h1000_0000 + 32'(i), 1'b1, i);
        send(0, csum ^ 32'h1, 1'b0, 0);
        wait_done(0);
        chk("bad_done", 64'(if0.io_done), 64'd1);
        chk("bad_err", 64'(if0.io_err), 64'd1);
        repeat (5) @(negedge clk);
        chk("bad_err_sticky", 64'(if0.io_err), 64'd1);

        // Backpressure before word 3; a stray start while busy must be ignored.
        start_load(0, sc);
        chk("restart_err_clr", 64'(if0.io_err), 64'd0);
        chk("restart_done_clr", 64'(if0.io_done), 64'd0);
        w2 = 32'h1000_0002;
        for (int i = 0; i < 3; i++) send(0, 32'h1000_0000 + 32'(i), 1'b1, i);
        if0.io_word_valid = 1'b0;
        repeat (3) @(negedge clk);
        for (int k = 0; k < 7; k++) begin
            chk("bp_ready", 64'(if0.io_word_ready), 64'd1);
            chk("bp_en", 64'(if0.io_configs_en), 64'd0);
            chk("bp_d_out", 64'(if0.io_d_out), 64'(w2));
            if0.io_start = (k == 2);
            @(negedge clk);
        end
        if0.io_start = 1'b0;
        for (int i = 3; i < N0; i++) send(0, 32'h1000_0000 + 32'(i), 1'b1, i);
        send(0, csum, 1'b0, 0);
        wait_done(0);
        chk("bp_done", 64'(if0.io_done), 64'd1);
        chk("bp_err", 64'(if0.io_err), 64'd0);
        chk("bp_sb_drained", 64'(sb0.size()), 64'd0);

        // Abort during the strobe of idx 10.
        start_load(0, sc);
        for (int i = 0; i <= 10; i++) send(0, 32'h2000_0000 + 32'(i), 1'b1, i);
        w10 = 32'h2000_000A;
        @(negedge clk);
        chk("abort_pre_en", 64'(if0.io_configs_en), 64'd1 << 10);
        if0.io_abort = 1'b1;
        @(negedge clk);
        if0.io_abort = 1'b0;
        chk("abort_en", 64'(if0.io_configs_en), 64'd0);
        chk("abort_busy", 64'(if0.io_busy), 64'd0);
        chk("abort_d_out", 64'(if0.io_d_out), 64'(w10));
        chk("abort_done", 64'(if0.io_done), 64'd0);
        if0.io_abort = 1'b1;
        @(negedge clk);
        if0.io_abort = 1'b0;
        chk("abort_idle_busy", 64'(if0.io_busy), 64'd0);
        chk("abort_idle_d_out", 64'(if0.io_d_out), 64'(w10));
        if0.io_start = 1'b1;
        if0.io_abort = 1'b1;
        @(negedge clk);
        if0.io_start = 1'b0;
        if0.io_abort = 1'b0;
        chk("start_wins_busy", 64'(if0.io_busy), 64'd1);
        chk("start_wins_ready", 64'(if0.io_word_ready), 64'd1);

        // Restarted load runs from idx 0; async reset during the strobe of idx 20.
        for (int i = 0; i <= 20; i++) send(0, 32'hA5A5_0000 + 32'(i), 1'b1, i);
        @(negedge clk);
        chk("rst_mid_pre_en", 64'(if0.io_configs_en), 64'd1 << 20);
        #1 reset = 1'b1;
        #1;
        chk("rst_mid_en", 64'(if0.io_configs_en), 64'd0);
        chk("rst_mid_d_out", 64'(if0.io_d_out), 64'd0);
        chk("rst_mid_busy", 64'(if0.io_busy), 64'd0);
        chk("rst_mid_ready", 64'(if0.io_word_ready), 64'd0);
        if0.io_word_valid = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("rst_mid_idle", 64'(if0.io_busy), 64'd0);
        chk("rst_mid_sb_drained", 64'(sb0.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
